cplx_op_sequencer: RTL and testbench

CPLX_OP_SEQUENCER -- requirements
Module: cplx_op_sequencer

---
 rtl/cplx_pkg.sv | 35 +++
 rtl/cplx_op_sequencer_if.sv | 36 +++
 rtl/cplx_div_watchdog.sv | 27 ++
 rtl/cplx_op_sequencer.sv | 110 +++++++++++
 tb/tb_cplx_op_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/cplx_pkg.sv
// Shared constants, opcodes and FSM state encoding for the complex-op sequencer.
package cplx_pkg;

    localparam int NUMBER_SIZE = 8;
    localparam int OP_SIZE     = 4;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [OP_SIZE-1:0] OP_ADD     = 4'b0000;
    localparam logic [OP_SIZE-1:0] OP_SUB     = 4'b0001;
    localparam logic [OP_SIZE-1:0] OP_MUL     = 4'b0010;
    localparam logic [OP_SIZE-1:0] OP_DIV     = 4'b0011;
    localparam logic [OP_SIZE-1:0] OP_CONJ    = 4'b0100;
    localparam logic [OP_SIZE-1:0] OP_NEG     = 4'b0101;
    localparam logic [OP_SIZE-1:0] OP_EQ      = 4'b1001;
    localparam logic [OP_SIZE-1:0] OP_NEQ     = 4'b1010;
    localparam logic [OP_SIZE-1:0] OP_LESS    = 4'b1011;
    localparam logic [OP_SIZE-1:0] OP_LEQ     = 4'b1100;
    localparam logic [OP_SIZE-1:0] OP_GREATER = 4'b1101;
    localparam logic [OP_SIZE-1:0] OP_GEQ     = 4'b1110;

    typedef logic [1:0] state_t;

    localparam state_t IDLE     = 2'd0;
    localparam state_t ALU_EXEC = 2'd1;
    localparam state_t DIV_WAIT = 2'd2;
    localparam state_t RESULT   = 2'd3;

    // Compare opcodes occupy a contiguous range and report through res_flag.
    function automatic logic is_compare(input logic [OP_SIZE-1:0] op);
        return (op >= OP_EQ) && (op <= OP_GEQ);
    endfunction

endpackage

// File: rtl/cplx_op_sequencer_if.sv
// Instruction, ALU, divider and result signals between the sequencer and its neighbours.
interface cplx_seq_if #(
    parameter int NUMBER_SIZE = 8,
    parameter int OP_SIZE     = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [OP_SIZE-1:0]       in_op;
    logic [2*NUMBER_SIZE-1:0] in_a;
    logic [2*NUMBER_SIZE-1:0] in_b;

    logic [OP_SIZE-1:0]       alu_op;
    logic [2*NUMBER_SIZE-1:0] alu_a;
    logic [2*NUMBER_SIZE-1:0] alu_b;
    logic [2*NUMBER_SIZE-1:0] alu_out;

    logic                     div_start;
    logic                     div_done;
    logic [2*NUMBER_SIZE-1:0] div_q;

    logic                     res_valid;
    logic                     res_ready;
    logic [2*NUMBER_SIZE-1:0] res;
    logic                     res_flag;
    logic                     res_err;

    modport master (
        output in_valid, in_op, in_a, in_b, alu_out, div_done, div_q, res_ready,
        input  in_ready, alu_op, alu_a, alu_b, div_start, res_valid, res, res_flag, res_err
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, alu_out, div_done, div_q, res_ready,
        output in_ready, alu_op, alu_a, alu_b, div_start, res_valid, res, res_flag, res_err
    );
endinterface

// File: rtl/cplx_div_watchdog.sv
// Counts cycles spent waiting on the divider and flags when the wait limit is reached.
module cplx_div_watchdog #(
    parameter int TIMEOUT = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // expired fires during the TIMEOUT-th enabled cycle so the caller leaves on that edge.
    assign expired = enable && (count == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/cplx_op_sequencer.sv
// Sequences complex ALU and divider operations behind valid/ready handshakes.
// Optional divider timeout: define CPLX_SEQ_DIV_TIMEOUT_EN.
module cplx_op_sequencer #(
    parameter int NUMBER_SIZE = 8,
    parameter int OP_SIZE     = 4,
    parameter int DIV_TIMEOUT = 32
) (
    input logic      clk,
    input logic      rst,
    cplx_seq_if.slave bus
);
    import cplx_pkg::*;

    state_t                   state;
    logic [OP_SIZE-1:0]       op_r;
    logic [2*NUMBER_SIZE-1:0] a_r;
    logic [2*NUMBER_SIZE-1:0] b_r;
    logic [2*NUMBER_SIZE-1:0] res_r;
    logic                     flag_r;
    logic                     err_r;
    logic                     start_r;
    logic                     accept;
    logic                     div_timeout;

    assign accept        = bus.in_valid && (state == IDLE);
    assign bus.in_ready  = (state == IDLE);
    assign bus.res_valid = (state == RESULT);
    assign bus.alu_op    = op_r;
    assign bus.alu_a     = a_r;
    assign bus.alu_b     = b_r;
    assign bus.res       = res_r;
    assign bus.res_flag  = flag_r;
    assign bus.res_err   = err_r;
    assign bus.div_start = start_r;

`ifdef CPLX_SEQ_DIV_TIMEOUT_EN
    cplx_div_watchdog #(
        .TIMEOUT (DIV_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != DIV_WAIT),
        .enable  (state == DIV_WAIT),
        .expired (div_timeout)
    );
`else
    assign div_timeout = FALSE;
`endif

    // A divide by zero is routed through ALU_EXEC so its result appears with ALU latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            op_r    <= '0;
            a_r     <= '0;
            b_r     <= '0;
            res_r   <= '0;
            flag_r  <= FALSE;
            err_r   <= FALSE;
            start_r <= FALSE;
        end else begin
            start_r <= FALSE;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= bus.in_op;
                        a_r   <= bus.in_a;
                        b_r   <= bus.in_b;
                        err_r <= FALSE;
                        if ((bus.in_op == OP_DIV) && (bus.in_b != '0)) begin
                            start_r <= TRUE;
                            state   <= DIV_WAIT;
                        end else begin
                            state <= ALU_EXEC;
                        end
                    end
                end
                ALU_EXEC: begin
                    if (op_r == OP_DIV) begin
                        res_r <= '0;
                        err_r <= TRUE;
                    end else begin
                        res_r <= bus.alu_out;
                        if (is_compare(op_r)) begin
                            flag_r <= bus.alu_out[0];
                        end
                    end
                    state <= RESULT;
                end
                DIV_WAIT: begin
                    if (bus.div_done) begin
                        res_r <= bus.div_q;
                        err_r <= FALSE;
                        state <= RESULT;
                    end else if (div_timeout) begin
                        res_r <= '0;
                        err_r <= TRUE;
                        state <= RESULT;
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cplx_op_sequencer.sv
// Directed self-checking bench for cplx_op_sequencer with a small complex ALU model.
module tb_cplx_op_sequencer;
    import cplx_pkg::*;

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;
    int   pulses;
    int   waited;

    cplx_seq_if #(.NUMBER_SIZE(8), .OP_SIZE(4)) bus ();

    cplx_op_sequencer #(
        .NUMBER_SIZE (8),
        .OP_SIZE     (4),
        .DIV_TIMEOUT (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational complex ALU stand-in: {real,imag} of 8-bit two's complement parts.
    function automatic logic [15:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [7:0] ar, ai, br, bi;
        ar = a[15:8]; ai = a[7:0]; br = b[15:8]; bi = b[7:0];
        case (op)
            OP_ADD:  return {8'(ar + br), 8'(ai + bi)};
            OP_MUL:  return {8'(ar * br - ai * bi), 8'(ar * bi + ai * br)};
            OP_LESS: return ($signed(ar) < $signed(br)) ? 16'hFFFF : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    assign bus.alu_out = aluModel(bus.alu_op, bus.alu_a, bus.alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Offers one instruction and returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = 4'b0000;
        bus.in_a      = 16'h0000;
        bus.in_b      = 16'h0000;
        bus.res_ready = 1'b1;
        bus.div_done  = 1'b0;
        bus.div_q     = 16'h0000;
        #12;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'h1);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'h0);
        checkOutput("rst_div_start", 32'(bus.div_start), 32'h0);
        checkOutput("rst_flag_err", {30'd0, bus.res_flag, bus.res_err}, 32'h0);
        checkOutput("rst_res", 32'(bus.res), 32'h0);
        checkOutput("rst_alu", {bus.alu_a, bus.alu_b}, 32'h0);
        checkOutput("rst_alu_op", 32'(bus.alu_op), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // ADD
        applyStimulus(OP_ADD, 16'h0304, 16'h0102);
        checkOutput("add_lat_early", 32'(bus.res_valid), 32'h0);
        checkOutput("add_alu_regs", {bus.alu_a, bus.alu_b}, 32'h0304_0102);
        tick();
        checkOutput("add_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("add_res", 32'(bus.res), 32'h0406);
        checkOutput("add_flag", 32'(bus.res_flag), 32'h0);
        tick();
        checkOutput("add_back_idle", 32'(bus.in_ready), 32'h1);

        // MUL then LESS
        applyStimulus(OP_MUL, 16'h0102, 16'h0304);
        tick();
        checkOutput("mul_res", 32'(bus.res), 32'hFB0A);
        tick();
        applyStimulus(OP_LESS, 16'h0200, 16'h0500);
        tick();
        checkOutput("less_res", 32'(bus.res), 32'hFFFF);
        checkOutput("less_flag", 32'(bus.res_flag), 32'h1);
        tick();

        // DIV with a 5-cycle divider and a stalled consumer
        bus.res_ready = 1'b0;
        applyStimulus(OP_DIV, 16'h0E02, 16'h0200);
        pulses = int'(bus.div_start);
        checkOutput("div_start_pulse", 32'(bus.div_start), 32'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            pulses += int'(bus.div_start);
            checkOutput("div_wait_valid", 32'(bus.res_valid), 32'h0);
        end
        @(negedge clk);
        bus.div_done = 1'b1;
        bus.div_q    = 16'h0701;
        tick();
        bus.div_done = 1'b0;
        pulses += int'(bus.div_start);
        checkOutput("div_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("div_res", 32'(bus.res), 32'h0701);
        checkOutput("div_err", 32'(bus.res_err), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("div_hold", {bus.res_valid, bus.in_ready, bus.res_err, 13'd0, bus.res}, {3'b100, 13'd0, 16'h0701});
        end
        checkOutput("div_start_count", 32'(pulses), 32'd1);
        bus.res_ready = 1'b1;
        tick();
        checkOutput("div_release", 32'(bus.in_ready), 32'h1);

        // DIV by zero
        applyStimulus(OP_DIV, 16'h0505, 16'h0000);
        checkOutput("dz_no_start", 32'(bus.div_start), 32'h0);
        checkOutput("dz_lat_early", 32'(bus.res_valid), 32'h0);
        tick();
        checkOutput("dz_valid", 32'(bus.res_valid), 32'h1);
        checkOutput("dz_res", 32'(bus.res), 32'h0);
        checkOutput("dz_err", 32'(bus.res_err), 32'h1);
        checkOutput("dz_no_start2", 32'(bus.div_start), 32'h0);
        tick();

        // Stray div_done in IDLE must not disturb anything
        @(negedge clk);
        bus.div_done = 1'b1;
        bus.div_q    = 16'h1234;
        tick();
        bus.div_done = 1'b0;
        checkOutput("stray_done_idle", {bus.in_ready, bus.res_valid, 14'd0, bus.res}, {2'b10, 14'd0, 16'h0000});

        // ADD after the error: err clears, compare flag held
        applyStimulus(OP_ADD, 16'h0101, 16'h0101);
        checkOutput("err_clear_accept", 32'(bus.res_err), 32'h0);
        tick();
        checkOutput("add2_res", 32'(bus.res), 32'h0202);
        checkOutput("add2_flag_held", 32'(bus.res_flag), 32'h1);
        tick();

        // Divider that never answers
        applyStimulus(OP_DIV, 16'h0404, 16'h0100);
`ifdef CPLX_SEQ_DIV_TIMEOUT_EN
        waited = 1;
        while (!bus.res_valid && waited < 40) begin
            tick();
            if (!bus.res_valid) waited++;
        end
        checkOutput("to_cycles", 32'(waited), 32'd32);
        checkOutput("to_err", 32'(bus.res_err), 32'h1);
        checkOutput("to_res", 32'(bus.res), 32'h0);
        tick();
`else
        for (int i = 1; i < 100; i++) tick();
        checkOutput("no_to_still_wait", {30'd0, bus.res_valid, bus.in_ready}, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
`endif

        // Reset in the middle of DIV_WAIT, then a late div_done
        applyStimulus(OP_DIV, 16'h0909, 16'h0300);
        tick();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.div_done = 1'b1;
        bus.div_q    = 16'h5555;
        tick();
        bus.div_done = 1'b0;
        tick();
        checkOutput("rst_mid_idle", {30'd0, bus.in_ready, bus.res_valid}, 32'h2);
        checkOutput("rst_mid_res", 32'(bus.res), 32'h0);
        checkOutput("rst_mid_start", 32'(bus.div_start), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
